// File: rtl/ip2_line_loader.sv
// ip2_line_loader: packs a 32-bit valid/ready word stream into 128-bit lines
// and writes them into the IP2 input memory. The two memory banks are used
// ping-pong: each full frame hands its bank to the sequencer, and the loader
// stalls while the next bank is still waiting to be released.
//
// Ports:
//   CLK, RST          rising-edge clock, asynchronous active-high reset
//   START             one-cycle pulse: (re)start at bank 0, line 0, flags clear
//   IN_DATA/IN_VALID  stream word and its valid flag
//   IN_READY          word accepted this cycle (high only while packing)
//   BANK_RELEASE      one-cycle pulse: bank REL_BANK has been consumed
//   REL_BANK          bank being released
//   WADDRO/BANKO      line address and bank for the IP2 write port
//   WCEBO             active-low write strobe, low for one cycle per line
//   DO                line data, word 0 in the LSBs
//   FRAME_DONE        pulse coincident with the write of the last frame line
//   FRAME_BANK        bank just completed, valid while FRAME_DONE=1
//   BUSY              per-bank "full, awaiting release" flags
module ip2_line_loader #(
  parameter int unsigned AW          = 14,
  parameter int unsigned FRAME_LINES = 16384
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [31:0]   IN_DATA,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic          BANK_RELEASE,
  input  logic          REL_BANK,
  output logic [AW-1:0] WADDRO,
  output logic          BANKO,
  output logic          WCEBO,
  output logic [127:0]  DO,
  output logic          FRAME_DONE,
  output logic          FRAME_BANK,
  output logic [1:0]    BUSY
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LINE_W = 128;
  localparam logic [AW-1:0] LAST_LINE = AW'(FRAME_LINES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PACK      = 2'd1,
    WAIT_BANK = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              word_cnt_q, word_cnt_d;
  logic [AW-1:0]           line_addr_q, line_addr_d;
  logic                    bank_q, bank_d;
  logic [2:0][WORD_W-1:0]  slot_q, slot_d;

  logic [AW-1:0]           waddr_d;
  logic                    banko_d;
  logic                    wceb_d;
  logic [LINE_W-1:0]       do_d;
  logic                    fdone_d;
  logic                    fbank_d;
  logic [1:0]              busy_d;
  logic                    ready_d;

  logic [1:0]              rel_mask;
  logic [1:0]              set_mask;
  logic [1:0]              busy_rel;

  // Release clears a flag; the completed frame's flag is set one edge after
  // its FRAME_DONE cycle, and set overrides a same-edge release.
  assign rel_mask = {2{BANK_RELEASE}} & {REL_BANK, ~REL_BANK};
  assign set_mask = {2{FRAME_DONE}} & {FRAME_BANK, ~FRAME_BANK};
  assign busy_rel = BUSY & ~rel_mask;

  // State and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      word_cnt_q  <= 2'd0;
      line_addr_q <= '0;
      bank_q      <= 1'b0;
      slot_q      <= '0;
      WADDRO      <= '0;
      BANKO       <= 1'b0;
      WCEBO       <= 1'b1;
      DO          <= '0;
      FRAME_DONE  <= 1'b0;
      FRAME_BANK  <= 1'b0;
      BUSY        <= 2'b00;
      IN_READY    <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      line_addr_q <= line_addr_d;
      bank_q      <= bank_d;
      slot_q      <= slot_d;
      WADDRO      <= waddr_d;
      BANKO       <= banko_d;
      WCEBO       <= wceb_d;
      DO          <= do_d;
      FRAME_DONE  <= fdone_d;
      FRAME_BANK  <= fbank_d;
      BUSY        <= busy_d;
      IN_READY    <= ready_d;
    end
  end

  // Next-state, packing and write generation
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    line_addr_d = line_addr_q;
    bank_d      = bank_q;
    slot_d      = slot_q;
    waddr_d     = WADDRO;
    banko_d     = BANKO;
    wceb_d      = 1'b1;
    do_d        = DO;
    fdone_d     = 1'b0;
    fbank_d     = FRAME_BANK;
    busy_d      = busy_rel | set_mask;

    if (START) begin
      // Any partial line is dropped; a write already on the port completes.
      state_d     = PACK;
      word_cnt_d  = 2'd0;
      line_addr_d = '0;
      bank_d      = 1'b0;
      busy_d      = 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
        end

        PACK: begin
          if (IN_VALID) begin
            word_cnt_d = word_cnt_q + 2'd1;
            case (word_cnt_q)
              2'd0: slot_d[0] = IN_DATA;
              2'd1: slot_d[1] = IN_DATA;
              2'd2: slot_d[2] = IN_DATA;
              default: begin
                // Fourth word goes straight to the line register: no bubble.
                do_d    = {IN_DATA, slot_q[2], slot_q[1], slot_q[0]};
                waddr_d = line_addr_q;
                banko_d = bank_q;
                wceb_d  = 1'b0;
                if (line_addr_q == LAST_LINE) begin
                  fdone_d     = 1'b1;
                  fbank_d     = bank_q;
                  line_addr_d = '0;
                  bank_d      = ~bank_q;
                  if (busy_rel[~bank_q]) begin
                    state_d = WAIT_BANK;
                  end
                end else begin
                  line_addr_d = line_addr_q + AW'(1);
                end
              end
            endcase
          end
        end

        WAIT_BANK: begin
          if (!BUSY[bank_q]) begin
            state_d = PACK;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    ready_d = (state_d == PACK);
  end

endmodule

// File: doc/ip2_line_loader.md
Name: ip2_line_loader

Overview:
Upstream feeder for the IP2 input memory write port (WADDRI/BANKI/WCEBI/DI). It accepts a 32-bit word stream with a valid/ready handshake and packs each group of four words into one 128-bit line. Each line is written to the current ping-pong bank. When a frame is complete, the bank is handed to the IP2 sequencer, and the loader stalls if the other bank has not yet been released.

Parameters:
AW, 14, line address width; must match the IP2 WADDRI width.
FRAME_LINES, 16384, lines per frame per bank; 2 <= FRAME_LINES <= 2^AW.

Ports:
CLK  in  1  clock; all logic is rising-edge.
RST  in  1  asynchronous reset, active-high.
START  in  1  one-cycle pulse; begins or restarts loading at bank 0, line 0.
IN_DATA  in  32  stream word.
IN_VALID  in  1  IN_DATA is valid.
IN_READY  out  1  loader accepts a word this cycle.
BANK_RELEASE  in  1  one-cycle pulse from the sequencer: the bank in REL_BANK has been consumed.
REL_BANK  in  1  bank being released.
WADDRO  out  AW  line address; drives IP2 WADDRI.
BANKO  out  1  target bank; drives IP2 BANKI.
WCEBO  out  1  write enable, active-low; drives IP2 WCEBI.
DO  out  128  line data; drives IP2 DI.
FRAME_DONE  out  1  one-cycle pulse, coincident with the last line's write cycle.
FRAME_BANK  out  1  bank just completed; valid while FRAME_DONE=1.
BUSY  out  2  per-bank "full, awaiting release" flags.

Behaviour:
Reset (async, RST=1):
- WADDRO=0, BANKO=0, WCEBO=1, DO=0, FRAME_DONE=0, FRAME_BANK=0, BUSY=00, IN_READY=0.
- Word count=0, line address=0, current bank=0, state=IDLE.

States: IDLE, PACK, WAIT_BANK.
- IN_READY=1 only in PACK. It is a decode of the registered state, with no combinational path from IN_VALID.
- IDLE: IN_READY=0. START moves to PACK.

START handling (any state):
- Clears word count, line address, current bank and BUSY, then enters PACK next cycle.
- A partial line is discarded.
- A write already registered for this cycle still completes.

PACK:
- Handshake: IN_VALID & IN_READY stores IN_DATA into slot k. Slot k occupies DO bits [32k+31:32k]; word 0 is the LSBs.
- On the 4th accepted word, the next cycle presents:
  - DO = {w3,w2,w1,w0}
  - WADDRO = line address
  - BANKO = current bank
  - WCEBO = 0 for exactly one cycle
- Latency is one cycle from the 4th handshake to the write. There is no bubble, so sustained throughput is one word per cycle and one write per 4 cycles.
- DO, WADDRO and BANKO hold their values when WCEBO=1.
- Line address increments after each write.
- Gaps in IN_VALID leave the partial line held indefinitely.

Frame completion (write of line FRAME_LINES-1):
- In the same write cycle: FRAME_DONE=1, FRAME_BANK=current bank.
- BUSY[current bank] sets on the next edge.
- Line address wraps to 0; current bank toggles.
- If BUSY[new bank]=1 after release is applied, go to WAIT_BANK; otherwise stay in PACK, and the first word of the next frame may be accepted in the cycle after the 4th handshake.

WAIT_BANK:
- IN_READY=0.
- Returns to PACK on the cycle after BUSY[current bank] clears.

Release:
- BANK_RELEASE clears BUSY[REL_BANK] on the next edge.
- Release of a non-busy bank is ignored.
- If release and set hit the same bank in the same cycle, set wins.
- If release and START occur in the same cycle, START wins (all flags clear).

Boundaries:
- IN_VALID while IN_READY=0: the word is not consumed; the source must hold it.
- Reset mid-frame: immediate return to the reset values; no write is emitted.
- Both banks busy: the loader stalls in WAIT_BANK with no writes.

Test Plan:
- Reset: assert RST mid-stream at an arbitrary time -> all outputs take reset values immediately, with WCEBO=1 and IN_READY=0.
- Packing: with FRAME_LINES=4, START, then words 0x00000001..0x00000004 back-to-back -> one cycle after the 4th handshake, WCEBO=0 for 1 cycle with DO=0x00000004_00000003_00000002_00000001, WADDRO=0, BANKO=0.
- Frame and bank swap: stream 16 words -> writes at addresses 0,1,2,3 in bank 0; FRAME_DONE pulses with the address-3 write and FRAME_BANK=0; BUSY=01 afterwards. The next 16 words go to bank 1 at addresses 0..3.
- Stall and release:
  - After two frames, BUSY=11, IN_READY=0, state WAIT_BANK, and no writes despite IN_VALID=1.
  - Pulse BANK_RELEASE with REL_BANK=0 -> BUSY=10; IN_READY rises the cycle after; the next write goes to bank 0, address 0.
- Same-cycle collision: BANK_RELEASE with REL_BANK=1 coincident with the bank-1 FRAME_DONE write -> BUSY[1] stays 1.
- Restart: START after 2 words of a line -> those words are dropped; the next 4 words write to bank 0, address 0, and BUSY=00.
